// File: rtl/core_c1_mau.sv
// Memory access unit: runs execute-stage loads/stores over a valid/ready data bus,
// stalls the pipeline until completion, extends load data and flags faults.
module core_c1_mau #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [4:0]  req_rd_idx,
  output logic        mau_pause,
  output logic        mem_cmd_valid,
  input  logic        mem_cmd_ready,
  output logic [31:0] mem_cmd_addr,
  output logic        mem_cmd_we,
  output logic [31:0] mem_cmd_wdata,
  output logic [3:0]  mem_cmd_wstrb,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata,
  input  logic        mem_rsp_err,
  output logic        wb_rd_valid,
  output logic [4:0]  wb_rd_idx,
  output logic [31:0] wb_rd_data,
  output logic        exception_load_misaligned,
  output logic        exception_store_misaligned,
  output logic        exception_access_fault,
  output logic [31:0] fault_addr
);

  typedef enum logic [1:0] {IDLE, CMD, RSP, DONE} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        we_q, uns_q, lmis_q, smis_q, err_q, tout_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  size_q;
  logic [4:0]  rd_q;
  logic [15:0] cnt_q;
  logic        req_mis, cnt_hit;

  always_comb begin
    case (req_size)
      2'b00:   req_mis = 1'b0;
      2'b01:   req_mis = req_addr[0];
      default: req_mis = |req_addr[1:0];
    endcase
  end

  assign cnt_hit = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid) state_d = req_mis ? DONE : CMD;
      CMD:  if (mem_cmd_ready) state_d = RSP;
      RSP:  if (mem_rsp_valid || cnt_hit) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // fault_addr is loaded on entry to DONE so it is valid alongside the exception pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      lmis_q     <= 1'b0;
      smis_q     <= 1'b0;
      err_q      <= 1'b0;
      tout_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      size_q     <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      fault_addr <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          uns_q   <= req_unsigned;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          size_q  <= req_size;
          rd_q    <= req_rd_idx;
          lmis_q  <= req_mis && !req_we;
          smis_q  <= req_mis && req_we;
          err_q   <= 1'b0;
          tout_q  <= 1'b0;
          rdata_q <= '0;
          if (req_mis) fault_addr <= req_addr;
        end
        CMD: if (mem_cmd_ready) cnt_q <= '0;
        RSP: begin
          if (mem_rsp_valid) begin
            rdata_q <= mem_rsp_rdata;
            err_q   <= mem_rsp_err;
            if (mem_rsp_err) fault_addr <= addr_q;
          end else if (cnt_hit) begin
            tout_q     <= 1'b1;
            fault_addr <= addr_q;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  logic [31:0] st_data, ld_data;
  logic [3:0]  st_strb;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic        wb_ok;

  always_comb begin
    case (size_q)
      2'b00: begin
        st_data = {4{wdata_q[7:0]}};
        st_strb = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        st_data = {2{wdata_q[15:0]}};
        st_strb = 4'b0011 << addr_q[1:0];
      end
      default: begin
        st_data = wdata_q;
        st_strb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    case (addr_q[1:0])
      2'b00:   ld_b = rdata_q[7:0];
      2'b01:   ld_b = rdata_q[15:8];
      2'b10:   ld_b = rdata_q[23:16];
      default: ld_b = rdata_q[31:24];
    endcase
    ld_h = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (size_q)
      2'b00:   ld_data = uns_q ? {24'b0, ld_b} : {{24{ld_b[7]}}, ld_b};
      2'b01:   ld_data = uns_q ? {16'b0, ld_h} : {{16{ld_h[15]}}, ld_h};
      default: ld_data = rdata_q;
    endcase
  end

  assign wb_ok = (state_q == DONE) && !we_q && !lmis_q && !err_q && !tout_q && (rd_q != 5'd0);

  always_comb begin
    mau_pause     = 1'b0;
    mem_cmd_valid = 1'b0;
    mem_cmd_addr  = '0;
    mem_cmd_we    = 1'b0;
    mem_cmd_wdata = '0;
    mem_cmd_wstrb = '0;
    case (state_q)
      IDLE: mau_pause = req_valid;
      CMD: begin
        mau_pause     = 1'b1;
        mem_cmd_valid = 1'b1;
        mem_cmd_addr  = {addr_q[31:2], 2'b00};
        mem_cmd_we    = we_q;
        mem_cmd_wdata = we_q ? st_data : '0;
        mem_cmd_wstrb = we_q ? st_strb : '0;
      end
      RSP:     mau_pause = 1'b1;
      default: ;
    endcase
  end

  assign wb_rd_valid = wb_ok;
  assign wb_rd_idx   = wb_ok ? rd_q : '0;
  assign wb_rd_data  = wb_ok ? ld_data : '0;

  assign exception_load_misaligned  = (state_q == DONE) && lmis_q;
  assign exception_store_misaligned = (state_q == DONE) && smis_q;
  assign exception_access_fault     = (state_q == DONE) && (err_q || tout_q);

endmodule

// File: doc/core_c1_mau.md
Name: core_c1_mau

Overview:
- Memory access unit sitting directly downstream of the execute stage.
- Takes load/store requests from the execute stage and runs them over a valid/ready data-memory bus with a separate response channel.
- Holds the execute stage via a pause signal until the access completes.
- Returns sign/zero-extended load data to the register-file write port and flags misaligned and faulting accesses.

Parameters:
- TIMEOUT_CYCLES, 255: response cycles waited in RSP before declaring an access fault; legal range 1..65535.

Ports:
- clk  input  1  core clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  execute stage presents a memory instruction
- req_we  input  1  1 = store, 0 = load
- req_addr  input  32  effective byte address
- req_wdata  input  32  store data, LSB-aligned
- req_size  input  2  00 byte, 01 half, 10 word; 11 is illegal and treated as word
- req_unsigned  input  1  zero-extend load (LBU/LHU)
- req_rd_idx  input  5  load destination register
- mau_pause  output  1  pause request to execute stage
- mem_cmd_valid  output  1  bus command valid
- mem_cmd_ready  input  1  bus command accepted
- mem_cmd_addr  output  32  word-aligned address ({addr[31:2],2'b00})
- mem_cmd_we  output  1  write command
- mem_cmd_wdata  output  32  lane-replicated store data
- mem_cmd_wstrb  output  4  byte-lane write strobes
- mem_rsp_valid  input  1  response valid (read data or write ack)
- mem_rsp_rdata  input  32  read word
- mem_rsp_err  input  1  bus error with response
- wb_rd_valid  output  1  register write-back strobe
- wb_rd_idx  output  5  write-back register index
- wb_rd_data  output  32  extended load data
- exception_load_misaligned  output  1  one-cycle pulse
- exception_store_misaligned  output  1  one-cycle pulse
- exception_access_fault  output  1  one-cycle pulse; bus error or timeout
- fault_addr  output  32  req_addr of the faulting access, held until the next fault

Behaviour:
- Reset:
  - State returns to IDLE.
  - All outputs are 0; fault_addr is 0; timeout counter is 0.
  - Reset mid-transaction abandons the access; any late mem_rsp_valid after reset is ignored in IDLE.
- States: IDLE, CMD, RSP, DONE.
- Misalignment:
  - Half access is misaligned when addr[0]=1.
  - Word access is misaligned when addr[1:0]!=0.
  - Byte access is never misaligned.
- IDLE:
  - On req_valid, latch all req_* fields.
  - Aligned request: go to CMD.
  - Misaligned request: go to DONE with the matching misaligned flag set; no bus traffic.
  - mau_pause = req_valid (combinational) so the execute stage stalls in the request cycle.
- CMD:
  - mem_cmd_valid=1 with latched fields; fields stay stable while valid and not ready.
  - On mem_cmd_ready go to RSP and clear the timeout counter.
  - mau_pause=1.
- RSP:
  - mem_cmd_valid=0; mau_pause=1; counter increments each cycle.
  - mem_rsp_valid: capture rdata and err, go to DONE.
  - Counter reaching TIMEOUT_CYCLES without a response: go to DONE with the fault flag set.
  - A response arriving in the same cycle as the timeout wins: no fault.
- DONE (exactly one cycle):
  - mau_pause=0 so the execute stage retires this cycle.
  - req_valid is ignored (it is the same instruction).
  - Pulse the exception outputs per the latched flags.
  - mem_rsp_err also raises exception_access_fault.
  - For faults, load fault_addr.
  - wb_rd_valid=1 only for an error-free, aligned load with rd_idx!=0.
  - Always return to IDLE.
- Latency: aligned access with ready and response each immediate takes 4 cycles (IDLE, CMD, RSP, DONE).
- Stores:
  - Byte: wdata = {4{wdata[7:0]}}, wstrb = 0001<<addr[1:0].
  - Half: wdata = {2{wdata[15:0]}}, wstrb = 0011<<addr[1:0].
  - Word: wstrb = 1111.
  - Loads drive wstrb=0000.
- Loads:
  - Select byte lane addr[1:0] or half lane addr[1].
  - Sign-extend unless req_unsigned; word passes through.
- Write-back outputs hold 0 when wb_rd_valid=0.

Test Plan:
- LB addr 0x1003, rdata 0x80AA5511, ready and response immediate → wb_rd_data 0xFFFFFF80, wb_rd_valid in cycle 4, mau_pause high for 3 cycles.
- SH addr 0x2002, wdata 0x1234ABCD → mem_cmd_addr 0x2000, wdata 0xABCDABCD, wstrb 1100, no wb_rd_valid.
- LW addr 0x3001 → exception_load_misaligned pulse in DONE, fault_addr 0x3001, no mem_cmd_valid ever.
- LHU addr 0x4002, mem_cmd_ready held low for 5 cycles then high, rdata 0xBEEF0000 → command fields stable throughout, wb_rd_data 0x0000BEEF.
- LW addr 0x5000 with TIMEOUT_CYCLES=4 and no response → exception_access_fault after 4 RSP cycles, fault_addr 0x5000; with the response arriving on cycle 4 → normal write-back, no fault.
- rst_n asserted while in RSP, then a late mem_rsp_valid → all outputs 0, state IDLE, no write-back.
